// File: rtl/radix_mul.sv
// Sequential radix-4 unsigned mantissa multiplier: 2 multiplier bits per cycle, exact 2N-bit product.
// Optional zero-operand shortcut (PRE goes straight to DONE) when RADIX_MUL_ZERO_SKIP_EN is defined.
module radix_mul #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   M,
  input  logic [N-1:0]   Q,
  output logic           ready,
  output logic           done,
  output logic [2*N-1:0] product,
  output logic           normalize
);

  if ((N % 2) != 0 || N < 4) begin : g_bad_width
    $error("radix_mul: N must be even and >= 4");
  end

  localparam int CW = $clog2(N/2);
  localparam logic [CW-1:0] LAST_ITER = CW'(N/2 - 1);

  typedef enum logic [1:0] {IDLE, PRE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     m_q, m_d;
  logic [N-1:0]     q_q, q_d;
  logic [N+1:0]     m3_q, m3_d;
  logic [N+1:0]     hi_q, hi_d;
  logic [N-1:0]     lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*N-1:0]   product_q, product_d;
  logic [N+1:0]     pp;
  logic [N+1:0]     sum;

  // hi stays below 2^N between iterations, so hi + 3M always fits in N+2 bits.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    q_d       = q_q;
    m3_d      = m3_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (q_q[1:0])
      2'd0:    pp = '0;
      2'd1:    pp = {2'b00, m_q};
      2'd2:    pp = {1'b0, m_q, 1'b0};
      default: pp = m3_q;
    endcase
    sum = hi_q + pp;

    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = M;
          q_d     = Q;
          hi_d    = '0;
          lo_d    = '0;
          state_d = PRE;
        end
      end
      PRE: begin
        m3_d    = {2'b00, m_q} + {1'b0, m_q, 1'b0};
        cnt_d   = '0;
        state_d = RUN;
`ifdef RADIX_MUL_ZERO_SKIP_EN
        if (m_q == '0 || q_q == '0) begin
          product_d = '0;
          state_d   = DONE;
        end
`endif
      end
      RUN: begin
        hi_d  = {2'b00, sum[N+1:2]};
        lo_d  = {sum[1:0], lo_q[N-1:2]};
        q_d   = {2'b00, q_q[N-1:2]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          product_d = {sum, lo_q[N-1:2]};
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= '0;
      q_q       <= '0;
      m3_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      q_q       <= q_d;
      m3_q      <= m3_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign done      = (state_q == DONE);
  assign product   = product_q;
  assign normalize = product_q[2*N-1];

endmodule
